prirv32_ifu_prefetch: RTL and testbench
=======================================

Name: priRV32_ifu_prefetch

Overview:
Parametrised next-generation instruction fetch/decode front end. Owns the PC and issues word fetches to instruction memory over a req/ack handshake. Buffers fetched words with their PCs in a FIFO_DEPTH-deep prefetch queue. Presents the queue head, fully decoded (imm, rs1/rs2/rd, class, illegal), to the execute stage over valid/ready. Supports redirect (branch/jump/trap) with flush and drop of in-flight responses.

Parameters:
ADDR_W, 32, fetch address / PC width (≥3).
FIFO_DEPTH, 4, prefetch entries; power of two, ≥2.
RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] must be 0.

Ports:
clk_in  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
imem_req_o  out  1  fetch request; held until imem_ack_i.
imem_addr_o  out  ADDR_W  word-aligned fetch address; stable while imem_req_o high.
imem_ack_i  in  1  response valid; honoured only when imem_req_o=1.
imem_data_i  in  32  instruction word, valid with imem_ack_i.
redirect_i  in  1  one-cycle PC redirect request.
redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] forced to 0.
dec_valid_o  out  1  queue head valid.
dec_ready_i  in  1  execute accepts head.
dec_pc_o  out  ADDR_W  PC of head.
dec_instr_o  out  32  raw head word.
dec_imm_o  out  32  sign-extended immediate.
dec_rs1_o / dec_rs2_o / dec_rd_o  out  5 each  instr[19:15] / [24:20] / [11:7].
dec_class_o  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 MISC_MEM, 10 SYSTEM, 15 ILLEGAL.
dec_illegal_o  out  1  dec_class_o==15.

Behaviour:
- Reset: imem_req_o=0; pc=fetch address=RESET_PC; FIFO empty; state IDLE; dec_valid_o=0; all dec_* data outputs 0 while empty.
- FSM states:
  - IDLE: if count<FIFO_DEPTH and no redirect, go REQ (req rises next cycle, addr=pc).
  - REQ: imem_req_o=1.
    - On ack without redirect: push {pc, data}; pc+=4 (wraps modulo 2^ADDR_W).
    - After that push, stay REQ with the new addr if count_after<FIFO_DEPTH, else go IDLE.
  - DROP: imem_req_o=1 at the old addr until ack; ack data discarded; then REQ at the redirected pc, or IDLE if no space.
- Space check counts the in-flight slot: a request is issued only if count+1≤FIFO_DEPTH, so a push never hits a full queue.
- Latency: ack at cycle N → dec_valid_o=1 at N+1 (FIFO registered; decode combinational on head).
- Output handshake:
  - Pop on dec_valid_o&&dec_ready_i.
  - Head fields remain stable while valid&&!ready.
  - Push and pop in the same cycle: count unchanged.
- Redirect (highest priority):
  - FIFO flushed; a same-cycle pop or push is void; pc<=redirect_pc_i&~3.
  - From REQ: if ack coincides, discard data and go REQ at the new pc; otherwise go DROP.
  - From IDLE: go REQ at the new pc.
  - Second redirect during DROP: latest target wins.
  - dec_valid_o=0 the cycle after a redirect.
- Decode:
  - imm formats: I: sext instr[31:20]. S: sext {31:25, 11:7}. B: sext {31, 7, 30:25, 11:8, 0}. U: {31:12, 12'b0}. J: sext {31, 19:12, 20, 30:21, 0}.
  - imm format by class: I for JALR, LOAD, OP_IMM, MISC_MEM, SYSTEM; U for LUI and AUIPC; J for JAL; B for BRANCH; S for STORE.
  - imm=0 for OP and ILLEGAL (never X).
  - ILLEGAL: instr[1:0]!=2'b11, unknown opcode, JALR funct3!=0, or OP funct7 not 0000000/0100000.
- Reset mid-fetch: all state returns to reset values next cycle. Memory must tolerate an abandoned request.

Optional Feature:
Macro PRIRV32_IFU_PERF_EN.
- Defined: adds perf_fetch_cnt_o (32, out; increments on each accepted non-dropped ack) and perf_stall_cnt_o (32, out; increments each cycle imem_req_o&&!imem_ack_i).
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by redirect.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header priRV32_defs.vh: opcode constants (7'b0110111 etc.), CLASS_* 4-bit codes, FSM state encodings.
- Sub-module priRV32_sync_fifo:
  - Parameters WIDTH, DEPTH; ports push, pop, flush, count, head data.
  - Synchronous active-high reset, same clock.
- Decode stays as combinational logic in the top.

Test Plan:
- Reset RESET_PC=0x100, zero-latency ack memory, ready=1 → addrs 0x100, 0x104, 0x108 back-to-back; dec_pc_o follows one cycle after each ack.
- dec_ready_i=0, FIFO_DEPTH=4 → exactly 4 acks accepted, then imem_req_o=0. Raise ready → request reissued at 0x110 one cycle after the first pop.
- Redirect to 0x203 while request pending, ack 3 cycles later → that ack's data never appears. Next addr=0x200; dec_valid_o=0 until the 0x200 word arrives.
- Decode checks:
  - 0xFE010113 → class 7, imm=0xFFFFFFE0, rs1=2, rd=2.
  - 0x00000013 → class 7, imm 0.
  - 0x0000006F → class 2.
  - 0xFFFFFFFF → class 15, illegal=1, imm=0.
- Redirect in the same cycle as ack and pop → FIFO empty next cycle, addr=target, no stale data.
- PRIRV32_IFU_PERF_EN: 5 fetches with 2 wait cycles each → perf_fetch_cnt_o=5, perf_stall_cnt_o=10; a dropped ack does not count.

Source files
------------

// File: rtl/prirv32_ifu_prefetch_pkg.sv
// ============================================================================
// Module   : prirv32_ifu_prefetch_pkg
// Brief    : Opcodes, instruction classes, fetch FSM states and decode helpers
//            shared by the instruction prefetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prirv32_ifu_prefetch_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    CLASS_LUI      = 4'd0,
    CLASS_AUIPC    = 4'd1,
    CLASS_JAL      = 4'd2,
    CLASS_JALR     = 4'd3,
    CLASS_BRANCH   = 4'd4,
    CLASS_LOAD     = 4'd5,
    CLASS_STORE    = 4'd6,
    CLASS_OP_IMM   = 4'd7,
    CLASS_OP       = 4'd8,
    CLASS_MISC_MEM = 4'd9,
    CLASS_SYSTEM   = 4'd10,
    CLASS_ILLEGAL  = 4'd15
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Opcode values all carry 2'b11 in [1:0], so compressed encodings fall to ILLEGAL.
  function automatic instr_class_e classify(input logic [31:0] instr);
    instr_class_e cls;
    cls = CLASS_ILLEGAL;
    case (instr[6:0])
      OPC_LUI:      cls = CLASS_LUI;
      OPC_AUIPC:    cls = CLASS_AUIPC;
      OPC_JAL:      cls = CLASS_JAL;
      OPC_JALR:     cls = (instr[14:12] == 3'b000) ? CLASS_JALR : CLASS_ILLEGAL;
      OPC_BRANCH:   cls = CLASS_BRANCH;
      OPC_LOAD:     cls = CLASS_LOAD;
      OPC_STORE:    cls = CLASS_STORE;
      OPC_OP_IMM:   cls = CLASS_OP_IMM;
      OPC_OP:       cls = (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000)
                          ? CLASS_OP : CLASS_ILLEGAL;
      OPC_MISC_MEM: cls = CLASS_MISC_MEM;
      OPC_SYSTEM:   cls = CLASS_SYSTEM;
      default:      cls = CLASS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [31:0] imm_of(input instr_class_e cls, input logic [31:0] instr);
    logic [31:0] imm;
    imm = 32'd0;
    case (cls)
      CLASS_JALR, CLASS_LOAD, CLASS_OP_IMM, CLASS_MISC_MEM, CLASS_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      CLASS_LUI, CLASS_AUIPC:
        imm = {instr[31:12], 12'd0};
      CLASS_JAL:
        imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      CLASS_BRANCH:
        imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      CLASS_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      default:
        imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prirv32_ifu_prefetch_sync_fifo.sv
// ============================================================================
// Module   : prirv32_ifu_prefetch_sync_fifo
// Brief    : Registered synchronous FIFO with flush; flush voids same-cycle
//            push and pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prirv32_ifu_prefetch_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);

  always_ff @(posedge clk_in) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/prirv32_ifu_prefetch.sv
// ============================================================================
// Module   : prirv32_ifu_prefetch
// Brief    : Instruction fetch FSM, prefetch queue and combinational decode of
//            the queue head. Optional macro PRIRV32_IFU_PERF_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prirv32_ifu_prefetch
  import prirv32_ifu_prefetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk_in,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [ADDR_W-1:0] dec_pc_o,
  output logic [31:0]       dec_instr_o,
  output logic [31:0]       dec_imm_o,
  output logic [4:0]        dec_rs1_o,
  output logic [4:0]        dec_rs2_o,
  output logic [4:0]        dec_rd_o,
  output logic [3:0]        dec_class_o,
  output logic              dec_illegal_o
`ifdef PRIRV32_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, drop_addr_q, drop_addr_d, target;
  logic              push, pop, flush, space_after_pop, room_after_push;
  logic [CNT_W-1:0]  count, count_after_pop;
  logic [ADDR_W+31:0] head;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       head_instr;
  instr_class_e      cls;

  prirv32_ifu_prefetch_sync_fifo #(
    .WIDTH (ADDR_W + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({pc_q, imem_data_i}),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

  assign target          = redirect_pc_i & ~ADDR_W'(3);
  assign dec_valid_o     = (count != '0);
  assign pop             = dec_valid_o && dec_ready_i;
  assign count_after_pop = count - CNT_W'(pop);
  // One slot is always reserved for the request about to be issued.
  assign space_after_pop = int'(count_after_pop) < FIFO_DEPTH;
  assign room_after_push = (int'(count_after_pop) + 1) < FIFO_DEPTH;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          flush   = 1'b1;
          pc_d    = target;
          state_d = ST_REQ;
        end else if (space_after_pop) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          flush = 1'b1;
          pc_d  = target;
          if (!imem_ack_i) begin
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack_i) begin
          push    = 1'b1;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = room_after_push ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        // The bus address stays on drop_addr_q; only the resume PC follows redirects.
        if (redirect_i) begin
          flush = 1'b1;
          pc_d  = target;
        end
        if (imem_ack_i) state_d = (redirect_i || space_after_pop) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req_o  = (state_q != ST_IDLE);
  assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  assign head_pc    = head[ADDR_W+31:32];
  assign head_instr = head[31:0];

  always_comb begin
    cls           = classify(head_instr);
    dec_pc_o      = '0;
    dec_instr_o   = '0;
    dec_imm_o     = '0;
    dec_rs1_o     = '0;
    dec_rs2_o     = '0;
    dec_rd_o      = '0;
    dec_class_o   = '0;
    dec_illegal_o = 1'b0;
    if (dec_valid_o) begin
      dec_pc_o      = head_pc;
      dec_instr_o   = head_instr;
      dec_imm_o     = imm_of(cls, head_instr);
      dec_rs1_o     = head_instr[19:15];
      dec_rs2_o     = head_instr[24:20];
      dec_rd_o      = head_instr[11:7];
      dec_class_o   = cls;
      dec_illegal_o = (cls == CLASS_ILLEGAL);
    end
  end

`ifdef PRIRV32_IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && perf_fetch_q != '1) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (imem_req_o && !imem_ack_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prirv32_ifu_prefetch.sv
// ============================================================================
// Module   : tb_prirv32_ifu_prefetch
// Brief    : Directed bench with a queue-level reference model for the fetch
//            front end; counter checks under PRIRV32_IFU_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prirv32_ifu_prefetch;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst, req, ack, redirect, ready;
  logic [31:0] addr, data, redirect_pc;
  logic        dvalid, dill;
  logic [31:0] dpc, dinstr, dimm;
  logic [4:0]  drs1, drs2, drd;
  logic [3:0]  dcls;
`ifdef PRIRV32_IFU_PERF_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  always #5 clk = ~clk;

  prirv32_ifu_prefetch #(.ADDR_W(32), .FIFO_DEPTH(4), .RESET_PC(RPC)) dut (
    .clk_in        (clk),
    .rst           (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ack_i    (ack),
    .imem_data_i   (data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .dec_valid_o   (dvalid),
    .dec_ready_i   (ready),
    .dec_pc_o      (dpc),
    .dec_instr_o   (dinstr),
    .dec_imm_o     (dimm),
    .dec_rs1_o     (drs1),
    .dec_rs2_o     (drs2),
    .dec_rd_o      (drd),
    .dec_class_o   (dcls),
    .dec_illegal_o (dill)
`ifdef PRIRV32_IFU_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  // Instruction memory: ack after `lat` wait cycles, or on demand via force_ack.
  logic [31:0] prog [256];
  int          lat = 0;
  bit          auto_en = 1'b1;
  bit          force_ack = 1'b0;
  int          wcnt = 0;

  assign ack  = req && (force_ack || (auto_en && wcnt >= lat));
  assign data = prog[addr[9:2]];

  always @(posedge clk) begin
    if (!req || ack) wcnt <= 0;
    else             wcnt <= wcnt + 1;
  end

  int compared = 0, mismatched = 0, acks_seen = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void mdec(input logic [31:0] w, output logic [3:0] c, output logic [31:0] imm);
    case (w[6:0])
      7'h37: c = 4'd0;
      7'h17: c = 4'd1;
      7'h6F: c = 4'd2;
      7'h67: c = (w[14:12] == 3'd0) ? 4'd3 : 4'd15;
      7'h63: c = 4'd4;
      7'h03: c = 4'd5;
      7'h23: c = 4'd6;
      7'h13: c = 4'd7;
      7'h33: c = (w[31:25] == 7'h00 || w[31:25] == 7'h20) ? 4'd8 : 4'd15;
      7'h0F: c = 4'd9;
      7'h73: c = 4'd10;
      default: c = 4'd15;
    endcase
    case (c)
      4'd3, 4'd5, 4'd7, 4'd9, 4'd10: imm = {{20{w[31]}}, w[31:20]};
      4'd0, 4'd1:                    imm = {w[31:12], 12'h000};
      4'd2: imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      4'd4: imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      4'd6: imm = {{20{w[31]}}, w[31:25], w[11:7]};
      default: imm = 32'h0;
    endcase
  endfunction

  // Reference model: a queue of {pc, word} in fetch order, next fetch PC and
  // the address of a request whose response must be thrown away.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] exp_pc = RPC, drop_addr = 32'h0;
  bit          drop_pend = 1'b0, live = 1'b0;

  always @(negedge clk) begin
    logic [3:0]  c;
    logic [31:0] im;
    ent_t        e;
    if (live) begin
      check("valid", dvalid, q.size() > 0);
      if (q.size() > 0) begin
        mdec(q[0].ins, c, im);
        check("head", {dpc, dinstr, dcls, dimm, drs1, drs2, drd, dill},
              {q[0].pc, q[0].ins, c, im, q[0].ins[19:15], q[0].ins[24:20], q[0].ins[11:7], c == 4'd15});
      end else begin
        check("empty_zero", {dpc, dinstr, dcls, dimm, drs1, drs2, drd, dill}, 128'h0);
      end
      if (drop_pend)  check("drop_addr", {req, addr}, {1'b1, drop_addr});
      else if (req)   check("fetch_addr", addr, exp_pc);
    end
    if (req && ack) acks_seen++;
    if (rst) begin
      q.delete();
      exp_pc    = RPC;
      drop_pend = 1'b0;
      live      = 1'b1;
    end else if (live) begin
      if (redirect) begin
        q.delete();
        if (req) begin
          if (ack) drop_pend = 1'b0;
          else if (!drop_pend) begin
            drop_pend = 1'b1;
            drop_addr = exp_pc;
          end
        end
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (req && ack) begin
          if (drop_pend) drop_pend = 1'b0;
          else begin
            e.pc  = exp_pc;
            e.ins = prog[exp_pc[9:2]];
            q.push_back(e);
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect = 1'b0;
    force_ack = 1'b0;
    step();
    step();
    acks_seen = 0;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = {i[11:0], 5'd1, 3'b000, i[4:0], 7'h13};
    prog[64] = 32'hFE010113;  // addi x2,x2,-32
    prog[65] = 32'h00000013;  // nop
    prog[66] = 32'h0000006F;  // jal x0,0
    prog[67] = 32'hFFFFFFFF;
    prog[68] = 32'h123452B7;  // lui x5,0x12345
    prog[69] = 32'hFE112E23;  // sw x1,-4(x2)
    prog[70] = 32'hFE208CE3;  // beq x1,x2,-8
    prog[71] = 32'h00009067;  // jalr with funct3=1
    prog[72] = 32'h023100B3;  // mul: funct7 outside base ISA
    prog[73] = 32'h40208133;  // sub x2,x1,x2
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;

    // Reset state and back-to-back zero-latency fetch with decode pins.
    step(); step();
    check("rst_req_addr", {req, addr}, {1'b0, 32'h100});
    check("rst_dec", {dvalid, dpc, dinstr, dcls, dimm}, 101'h0);
    rst = 1'b0;
    step();
    check("t1_first_req", {req, addr}, {1'b1, 32'h100});
    step();
    check("t1_addr104", addr, 32'h104);
    check("t1_addi_dec", {dvalid, dpc, dcls, dimm, drs1, drd}, {1'b1, 32'h100, 4'd7, 32'hFFFFFFE0, 5'd2, 5'd2});
    step();
    check("t1_nop_dec", {addr, dpc, dcls, dimm}, {32'h108, 32'h104, 4'd7, 32'h0});
    step();
    check("t1_jal_dec", {dpc, dcls}, {32'h108, 4'd2});
    step();
    check("t1_illegal_dec", {dpc, dcls, dill, dimm}, {32'h10C, 4'd15, 1'b1, 32'h0});
    step();
    check("t1_lui_dec", {dcls, dimm, drd}, {4'd0, 32'h12345000, 5'd5});
    step();
    check("t1_sw_dec", {dcls, dimm, drs1, drs2}, {4'd6, 32'hFFFFFFFC, 5'd2, 5'd1});
    repeat (6) step();

    // Back-pressure: four entries fill the queue, then fetch stops.
    ready = 1'b0;
    apply_reset();
    repeat (10) step();
    check("t2_acks", acks_seen, 4);
    check("t2_req_low", {req, dvalid, dpc}, {1'b0, 1'b1, 32'h100});
    ready = 1'b1;
    step();
    check("t2_reissue", {req, addr, dpc}, {1'b1, 32'h110, 32'h104});
    repeat (6) step();

    // Redirect while a request is pending: its response is discarded.
    auto_en = 1'b0;
    apply_reset();
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check("t3_drop_hold", {req, addr, dvalid}, {1'b1, 32'h100, 1'b0});
    step(); step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("t3_resume", {req, addr, dvalid}, {1'b1, 32'h200, 1'b0});
    step();
    check("t3_still_empty", dvalid, 1'b0);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("t3_new_word", {dvalid, dpc, dinstr}, {1'b1, 32'h200, 32'h08008013});
    // Two redirects while dropping: the later target wins.
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_pc = 32'h501;
    step();
    redirect = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("t3_latest_wins", {req, addr, dvalid}, {1'b1, 32'h500, 1'b0});
    auto_en = 1'b1;
    repeat (6) step();

    // Redirect coinciding with an ack and a pop.
    apply_reset();
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    check("t4_flushed", {dvalid, req, addr}, {1'b0, 1'b1, 32'h300});
    step();
    check("t4_target_word", {dvalid, dpc, dinstr}, {1'b1, 32'h300, 32'h0C008013});
    repeat (4) step();

    // Slow memory with a stalled consumer and redirects under model checking.
    lat = 1;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      ready = (i % 3) != 0;
      redirect = (i == 17);
      redirect_pc = 32'h124;
      step();
    end
    redirect = 1'b0;
    ready = 1'b1;

`ifdef PRIRV32_IFU_PERF_EN
    lat = 2;
    apply_reset();
    for (int i = 0; i < 60 && acks_seen < 5; i++) step();
    check("perf_fetch5", perf_fetch, 32'd5);
    check("perf_stall10", perf_stall, 32'd10);
    auto_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h180;
    step();
    redirect = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("perf_drop_not_counted", perf_fetch, 32'd5);
    auto_en = 1'b1;
    lat = 0;
    repeat (4) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
